vdp_vram_slot_arbiter: RTL and testbench

Schedules the shared 32-bit VRAM port on the VDP's 4-clock access slot (DL/DA/AP/FS). Requesters are the super-res display fetcher, the CPU port and the command engine, plus periodic refresh. Sits between those requesters and the SDRAM/VRAM controller. Guarantees the display fetcher every slot of an active fetch line and shares the remaining slots fairly.

---
 rtl/vdp_vram_slot_arbiter_pkg.sv | 24 ++
 rtl/vdp_vram_slot_arbiter_refresh_timer.sv | 48 ++++
 rtl/vdp_vram_slot_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_vdp_vram_slot_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_vram_slot_arbiter_pkg.sv
// Shared types for the VDP VRAM slot arbiter: slot owners, slot phases, field widths.
package vdp_arb_pkg;

    typedef enum logic [2:0] {
        NONE,
        DISP,
        REFRESH,
        CPU,
        CMD
    } arb_owner_t;

    typedef enum logic [1:0] {
        DL,
        DA,
        AP,
        FS
    } slot_phase_t;

    localparam int unsigned REF_PEND_W = 3;
    localparam int unsigned ADDR_W     = 17;
    localparam int unsigned WDATA_W    = 8;
    localparam int unsigned RDATA_W    = 32;

endpackage

// File: rtl/vdp_vram_slot_arbiter_refresh_timer.sv
// Refresh timer: counts access slots and accumulates a saturating count of owed refreshes.
module vdp_arb_refresh_timer
    import vdp_arb_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  slot_tick,
    input  logic                  grant_dec,
    output logic [REF_PEND_W-1:0] pending
);

    localparam int unsigned      CNT_W    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);

    logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
    logic [REF_PEND_W-1:0] pend_q, pend_d;
    logic                  wrap;

    always_comb begin
        wrap       = slot_tick && (slot_cnt_q == CNT_LAST);
        slot_cnt_d = slot_cnt_q;
        if (slot_tick) begin
            slot_cnt_d = wrap ? '0 : slot_cnt_q + 1'b1;
        end
        // A wrap and a grant in the same slot cancel out.
        pend_d = pend_q;
        if (wrap && !grant_dec && (pend_q != '1)) begin
            pend_d = pend_q + 1'b1;
        end else if (!wrap && grant_dec && (pend_q != '0)) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt_q <= '0;
            pend_q     <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            pend_q     <= pend_d;
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/vdp_vram_slot_arbiter.sv
// Schedules the shared VRAM port over the 4-clock DL/DA/AP/FS slot.
// Optional CPU starvation guard: define VDP_ARB_STARVE_GUARD_EN.
module vdp_vram_slot_arbiter
    import vdp_arb_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = 64
`ifdef VDP_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = 8
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [10:0]        cx,
    input  logic               disp_active,
    input  logic [ADDR_W-1:0]  disp_addr,
    output logic               disp_ack,
    output logic               disp_rdata_valid,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic               cpu_wr,
    input  logic [WDATA_W-1:0] cpu_wdata,
    output logic               cpu_ack,
    output logic               cpu_rdata_valid,
    input  logic               cmd_req,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic               cmd_wr,
    input  logic [WDATA_W-1:0] cmd_wdata,
    output logic               cmd_ack,
    output logic               cmd_rdata_valid,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [WDATA_W-1:0] mem_wdata,
    output logic               mem_refresh,
    input  logic [RDATA_W-1:0] mem_rdata,
    output logic [RDATA_W-1:0] rdata
);

    slot_phase_t           phase_q, phase_d;
    arb_owner_t            owner_q, owner_d, sel;
    logic                  rr_cmd_q, rr_cmd_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [WDATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [RDATA_W-1:0]    rdata_q, rdata_d;
    logic                  mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, mem_ref_q, mem_ref_d;
    logic                  disp_ack_q, disp_ack_d, cpu_ack_q, cpu_ack_d, cmd_ack_q, cmd_ack_d;
    logic                  disp_val_q, disp_val_d, cpu_val_q, cpu_val_d, cmd_val_q, cmd_val_d;
    logic [REF_PEND_W-1:0] ref_pending;
    logic                  is_dl;
    logic                  force_cpu;

    assign is_dl = (phase_q == DL);

`ifdef VDP_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    assign force_cpu = cpu_req && (32'(starve_q) >= STARVE_LIMIT);

    always_comb begin
        starve_d = starve_q;
        if (is_dl) begin
            if (sel == CPU) begin
                starve_d = '0;
            end else if (cpu_req && (starve_q != '1)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_cpu = 1'b0;
`endif

    vdp_arb_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .slot_tick(is_dl),
        .grant_dec(is_dl && (sel == REFRESH)),
        .pending  (ref_pending)
    );

    always_comb begin
        sel = NONE;
        if (force_cpu) begin
            sel = CPU;
        end else if (disp_active) begin
            sel = DISP;
        end else if (ref_pending != '0) begin
            sel = REFRESH;
        end else if (cpu_req && (!cmd_req || !rr_cmd_q)) begin
            sel = CPU;
        end else if (cmd_req) begin
            sel = CMD;
        end
    end

    // Strobes are loaded only at a DL edge, so a slot whose DL was skipped by a cx jump
    // issues nothing, and a repeated DA phase cannot strobe twice.
    always_comb begin
        phase_d     = (cx == '0) ? DA : slot_phase_t'(phase_q + 2'd1);
        owner_d     = (phase_q == FS) ? NONE : owner_q;
        rr_cmd_d    = rr_cmd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        disp_ack_d  = is_dl && (sel == DISP);
        cpu_ack_d   = is_dl && (sel == CPU);
        cmd_ack_d   = is_dl && (sel == CMD);
        mem_rd_d    = is_dl && ((sel == DISP) || ((sel == CPU) && !cpu_wr) || ((sel == CMD) && !cmd_wr));
        mem_wr_d    = is_dl && (((sel == CPU) && cpu_wr) || ((sel == CMD) && cmd_wr));
        mem_ref_d   = is_dl && (sel == REFRESH);
        rdata_d     = (phase_q == DA) ? mem_rdata : rdata_q;
        disp_val_d  = mem_rd_q && (owner_q == DISP);
        cpu_val_d   = mem_rd_q && (owner_q == CPU);
        cmd_val_d   = mem_rd_q && (owner_q == CMD);
        if (is_dl) begin
            owner_d = sel;
            unique case (sel)
                DISP: mem_addr_d = disp_addr;
                CPU: begin
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    rr_cmd_d    = 1'b1;
                end
                CMD: begin
                    mem_addr_d  = cmd_addr;
                    mem_wdata_d = cmd_wdata;
                    rr_cmd_d    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= DL;
            owner_q     <= NONE;
            rr_cmd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_ref_q   <= 1'b0;
            disp_ack_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cmd_ack_q   <= 1'b0;
            disp_val_q  <= 1'b0;
            cpu_val_q   <= 1'b0;
            cmd_val_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            owner_q     <= owner_d;
            rr_cmd_q    <= rr_cmd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_ref_q   <= mem_ref_d;
            disp_ack_q  <= disp_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            cmd_ack_q   <= cmd_ack_d;
            disp_val_q  <= disp_val_d;
            cpu_val_q   <= cpu_val_d;
            cmd_val_q   <= cmd_val_d;
        end
    end

    assign disp_ack         = disp_ack_q;
    assign disp_rdata_valid = disp_val_q;
    assign cpu_ack          = cpu_ack_q;
    assign cpu_rdata_valid  = cpu_val_q;
    assign cmd_ack          = cmd_ack_q;
    assign cmd_rdata_valid  = cmd_val_q;
    assign mem_addr         = mem_addr_q;
    assign mem_rd           = mem_rd_q;
    assign mem_wr           = mem_wr_q;
    assign mem_wdata        = mem_wdata_q;
    assign mem_refresh      = mem_ref_q;
    assign rdata            = rdata_q;

endmodule

// File: tb/tb_vdp_vram_slot_arbiter.sv
// Self-checking bench for vdp_vram_slot_arbiter against a slot-level reference model.
module tb_vdp_vram_slot_arbiter;

    localparam int RI = 4;
    localparam int O_NONE = 0, O_DISP = 1, O_REF = 2, O_CPU = 3, O_CMD = 4;
`ifdef VDP_ARB_STARVE_GUARD_EN
    localparam int EXP_DISP10 = 9, EXP_CPU10 = 1;
`else
    localparam int EXP_DISP10 = 10, EXP_CPU10 = 0;
`endif

    logic        clk, reset_n;
    logic [10:0] cx;
    logic        disp_active, disp_ack, disp_rdata_valid;
    logic [16:0] disp_addr, cpu_addr, cmd_addr, mem_addr;
    logic        cpu_req, cpu_wr, cpu_ack, cpu_rdata_valid;
    logic        cmd_req, cmd_wr, cmd_ack, cmd_rdata_valid;
    logic [7:0]  cpu_wdata, cmd_wdata, mem_wdata;
    logic        mem_rd, mem_wr, mem_refresh;
    logic [31:0] mem_rdata, rdata;

    int n_checks = 0, n_fail = 0, slot_no = 0;

    // Reference model state, advanced once per DL
    int          m_pend, m_slotcnt, m_starve;
    bit          m_rr_cmd;
    logic [16:0] m_addr;
    logic [7:0]  m_wdata;

    vdp_vram_slot_arbiter #(.REFRESH_INTERVAL(RI)) dut (
        .clk(clk), .reset_n(reset_n), .cx(cx),
        .disp_active(disp_active), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rdata_valid(disp_rdata_valid),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata_valid(cpu_rdata_valid),
        .cmd_req(cmd_req), .cmd_addr(cmd_addr), .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata),
        .cmd_ack(cmd_ack), .cmd_rdata_valid(cmd_rdata_valid),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_refresh(mem_refresh), .mem_rdata(mem_rdata), .rdata(rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [65:0] outs();
        return {disp_ack, disp_rdata_valid, cpu_ack, cpu_rdata_valid, cmd_ack, cmd_rdata_valid,
                mem_rd, mem_wr, mem_refresh, mem_addr, mem_wdata, rdata};
    endfunction

    function automatic void model_reset();
        m_pend = 0; m_slotcnt = 0; m_starve = 0; m_rr_cmd = 0; m_addr = '0; m_wdata = '0;
    endfunction

    function automatic int model_pick();
`ifdef VDP_ARB_STARVE_GUARD_EN
        if (cpu_req && m_starve >= 8) return O_CPU;
`endif
        if (disp_active) return O_DISP;
        if (m_pend > 0) return O_REF;
        if (cpu_req && cmd_req) return m_rr_cmd ? O_CMD : O_CPU;
        if (cpu_req) return O_CPU;
        if (cmd_req) return O_CMD;
        return O_NONE;
    endfunction

    function automatic void model_advance(input int who);
        int wrap;
        wrap = (m_slotcnt == RI - 1) ? 1 : 0;
        m_slotcnt = (wrap == 1) ? 0 : m_slotcnt + 1;
        m_pend = m_pend + wrap - ((who == O_REF) ? 1 : 0);
        if (m_pend > 7) m_pend = 7;
        if (who == O_DISP) m_addr = disp_addr;
        if (who == O_CPU) begin m_addr = cpu_addr; m_wdata = cpu_wdata; m_rr_cmd = 1; end
        if (who == O_CMD) begin m_addr = cmd_addr; m_wdata = cmd_wdata; m_rr_cmd = 0; end
        if (who == O_CPU) m_starve = 0;
        else if (cpu_req && m_starve < 15) m_starve++;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset_n) cx = '0;
        else cx = (cx == 11'd1023) ? 11'd0 : cx + 11'd1;
    endtask

    task automatic do_reset();
        logic [65:0] obs;
        reset_n = 1'b0;
        disp_active = 0; cpu_req = 0; cmd_req = 0; cpu_wr = 0; cmd_wr = 0;
        disp_addr = '0; cpu_addr = '0; cmd_addr = '0; cpu_wdata = '0; cmd_wdata = '0;
        mem_rdata = '0; cx = '0;
        model_reset();
        tick();
        tick();
        obs = outs();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h required 0", obs);
        end
        reset_n = 1'b1;
    endtask

    // Entered and left on a DL cycle. jump: 0 none, 1 cx jump at FS (next slot loses DL),
    // 2 cx jump during DA (read must still complete).
    task automatic run_slot(input int jump, output int who);
        int          exp;
        logic        exp_rd, exp_wr;
        logic [5:0]  exp_stb, obs_stb;
        logic [2:0]  exp_val, obs_val;
        logic [31:0] rd_val;
        exp     = model_pick();
        exp_rd  = (exp == O_DISP) || (exp == O_CPU && !cpu_wr) || (exp == O_CMD && !cmd_wr);
        exp_wr  = (exp == O_CPU && cpu_wr) || (exp == O_CMD && cmd_wr);
        exp_stb = {exp == O_DISP, exp == O_CPU, exp == O_CMD, exp_rd, exp_wr, exp == O_REF};
        exp_val = exp_rd ? {exp == O_DISP, exp == O_CPU, exp == O_CMD} : 3'b000;
        model_advance(exp);
        tick();
        rd_val = $urandom();
        mem_rdata = rd_val;
        obs_stb = {disp_ack, cpu_ack, cmd_ack, mem_rd, mem_wr, mem_refresh};
        who = disp_ack ? O_DISP : cpu_ack ? O_CPU : cmd_ack ? O_CMD : mem_refresh ? O_REF : O_NONE;
        n_checks++;
        if (obs_stb !== exp_stb) begin
            n_fail++;
            $display("FAIL da_strobes slot %0d: got %b required %b", slot_no, obs_stb, exp_stb);
        end
        n_checks++;
        if (mem_addr !== m_addr || mem_wdata !== m_wdata) begin
            n_fail++;
            $display("FAIL da_addr_data slot %0d: got %h/%h required %h/%h",
                     slot_no, mem_addr, mem_wdata, m_addr, m_wdata);
        end
        if (jump == 2) cx = '0;
        tick();
        obs_val = {disp_rdata_valid, cpu_rdata_valid, cmd_rdata_valid};
        obs_stb = {disp_ack, cpu_ack, cmd_ack, mem_rd, mem_wr, mem_refresh};
        n_checks++;
        if (obs_val !== exp_val || obs_stb !== 6'b0) begin
            n_fail++;
            $display("FAIL ap_valid slot %0d: got %b/%b required %b/000000",
                     slot_no, obs_val, obs_stb, exp_val);
        end
        if (exp_rd) begin
            n_checks++;
            if (rdata !== rd_val) begin
                n_fail++;
                $display("FAIL ap_rdata slot %0d: got %h required %h", slot_no, rdata, rd_val);
            end
        end
        tick();
        n_checks++;
        if ({disp_ack, cpu_ack, cmd_ack, mem_rd, mem_wr, mem_refresh, disp_rdata_valid,
             cpu_rdata_valid, cmd_rdata_valid} !== 9'b0 || mem_addr !== m_addr) begin
            n_fail++;
            $display("FAIL fs_quiet slot %0d: got addr %h required %h with no strobes",
                     slot_no, mem_addr, m_addr);
        end
        if (jump == 2) tick();
        if (jump == 1) begin
            cx = '0;
            for (int c = 0; c < 3; c++) begin
                tick();
                n_checks++;
                if (outs() >> 57 !== 66'b0) begin
                    n_fail++;
                    $display("FAIL trunc_quiet slot %0d cyc %0d: got %b required 0",
                             slot_no, c, outs() >> 57);
                end
            end
        end
        tick();
        slot_no++;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2;
        do_reset();
    endtask

    task automatic test_cpu_read();
        int w;
        cpu_req = 1; cpu_addr = 17'h00123; cpu_wr = 0; cpu_wdata = 8'h5A;
        run_slot(0, w);
        cpu_req = 0;
        n_checks++;
        if (w != O_CPU) begin n_fail++; $display("FAIL cpu_read_owner: got %0d required %0d", w, O_CPU); end
    endtask

    task automatic test_round_robin();
        int w;
        int exp_rr[4] = '{O_CPU, O_CMD, O_CPU, O_CMD};
        do_reset();
        cpu_req = 1; cpu_addr = 17'h01000; cpu_wr = 0; cpu_wdata = 8'h11;
        cmd_req = 1; cmd_addr = 17'h1F00F; cmd_wr = 1; cmd_wdata = 8'hC3;
        for (int s = 0; s < 4; s++) begin
            run_slot(0, w);
            n_checks++;
            if (w != exp_rr[s]) begin
                n_fail++;
                $display("FAIL rr_order slot %0d: got %0d required %0d", s, w, exp_rr[s]);
            end
        end
        cpu_req = 0; cmd_req = 0;
    endtask

    task automatic test_disp_priority();
        int w, n_d, n_c, ninth;
        bit got;
        do_reset();
        cpu_req = 1; cpu_addr = 17'h00ABC; cpu_wr = 0; cpu_wdata = 8'h77;
        disp_active = 1;
        n_d = 0; n_c = 0; ninth = O_NONE;
        for (int s = 0; s < 10; s++) begin
            disp_addr = 17'($urandom());
            run_slot(0, w);
            if (w == O_DISP) n_d++;
            if (w == O_CPU) n_c++;
            if (s == 8) ninth = w;
        end
        n_checks++;
        if (n_d != EXP_DISP10 || n_c != EXP_CPU10) begin
            n_fail++;
            $display("FAIL disp_prio_counts: got disp %0d cpu %0d required %0d %0d",
                     n_d, n_c, EXP_DISP10, EXP_CPU10);
        end
        n_checks++;
        if (ninth != ((EXP_CPU10 == 1) ? O_CPU : O_DISP)) begin
            n_fail++;
            $display("FAIL disp_prio_ninth: got %0d required %0d", ninth, (EXP_CPU10 == 1) ? O_CPU : O_DISP);
        end
        disp_active = 0;
        got = 0;
        for (int s = 0; s < 30 && !got; s++) begin
            run_slot(0, w);
            if (w == O_CPU) got = 1;
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL disp_prio_drain: got no cpu grant, required one in 30 slots"); end
        cpu_req = 0;
    endtask

    task automatic test_refresh();
        int w, n_ref, first_ref, n_d, run;
        bit counting;
        do_reset();
        n_ref = 0; first_ref = -1;
        for (int s = 0; s < 12; s++) begin
            run_slot(0, w);
            if (w == O_REF) begin n_ref++; if (first_ref < 0) first_ref = s; end
        end
        n_checks++;
        if (n_ref != 2 || first_ref != 4) begin
            n_fail++;
            $display("FAIL refresh_idle: got %0d refreshes first at %0d required 2 first at 4", n_ref, first_ref);
        end
        disp_active = 1; n_d = 0;
        for (int s = 0; s < 40; s++) begin
            disp_addr = 17'($urandom());
            run_slot(0, w);
            if (w == O_DISP) n_d++;
        end
        n_checks++;
        if (n_d != 40) begin n_fail++; $display("FAIL refresh_disp_slots: got %0d required 40", n_d); end
        disp_active = 0; run = 0; counting = 1;
        for (int s = 0; s < 16; s++) begin
            run_slot(0, w);
            if (counting && w == O_REF) run++;
            else counting = 0;
        end
        n_checks++;
        if (run < 7) begin n_fail++; $display("FAIL refresh_burst: got %0d back-to-back required at least 7", run); end
    endtask

    task automatic test_cx_jump();
        int w;
        bit got;
        disp_active = 1; disp_addr = 17'h0AAAA;
        cpu_req = 1; cpu_addr = 17'h15555; cpu_wr = 0; cpu_wdata = 8'h3C;
        run_slot(1, w);
        disp_active = 0;
        got = 0;
        for (int s = 0; s < 20 && !got; s++) begin
            run_slot(2, w);
            if (w == O_CPU) got = 1;
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL cx_jump_grant: got no cpu grant, required one in 20 slots"); end
        cpu_req = 0;
    endtask

    task automatic test_random();
        int w;
        w = O_NONE;
        for (int s = 0; s < 120; s++) begin
            if (!cpu_req || w == O_CPU) begin
                cpu_req = 1'($urandom_range(0, 1)); cpu_addr = 17'($urandom());
                cpu_wr = 1'($urandom()); cpu_wdata = 8'($urandom());
            end
            if (!cmd_req || w == O_CMD) begin
                cmd_req = 1'($urandom_range(0, 1)); cmd_addr = 17'($urandom());
                cmd_wr = 1'($urandom()); cmd_wdata = 8'($urandom());
            end
            disp_active = ($urandom_range(0, 3) == 0);
            disp_addr = 17'($urandom());
            run_slot(0, w);
        end
        cpu_req = 0; cmd_req = 0; disp_active = 0;
    endtask

    task automatic test_reset_mid_slot();
        int w;
        logic [65:0] obs;
        do_reset();
        cpu_req = 1; cpu_addr = 17'h00456; cpu_wr = 0; cpu_wdata = 8'h99;
        tick();
        n_checks++;
        if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ack: got %b required 1", cpu_ack); end
        // Reset lands just before the edge into AP
        #7;
        reset_n = 1'b0;
        #1;
        obs = outs();
        n_checks++;
        if (obs !== '0) begin n_fail++; $display("FAIL mid_reset_clear: got %h required 0", obs); end
        do_reset();
        cpu_req = 1; cpu_addr = 17'h00789; cpu_wr = 0; cpu_wdata = 8'h42;
        run_slot(0, w);
        n_checks++;
        if (w != O_CPU) begin n_fail++; $display("FAIL post_reset_grant: got %0d required %0d", w, O_CPU); end
        cpu_req = 0;
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_disp_priority();
        test_refresh();
        test_cx_jump();
        test_random();
        test_reset_mid_slot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
